// File: rtl/dmem_dma_if.sv
// ----------------------------------------------------------------------------
// dmem_dma_if
// Bundles the control, status and data-memory signals of the DMA engine.
//   master : engine view  (drives status + memory request, receives control
//            + READ_DATA)
//   slave  : environment view (CPU control path and data memory)
// Signals:
//   START, MODE, ABORT, SRC, DST, LEN, FILL_DATA   control from software
//   BUSY, DONE, ABORTED, WORDS_DONE                status to software
//   MEM_WRITE, ADDRESS, WRITE_DATA                 memory request
//   READ_DATA                                      registered memory read data
// ----------------------------------------------------------------------------
interface dmem_dma_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 10
);
    logic                   START;
    logic                   MODE;
    logic                   ABORT;
    logic [ADDR_BITS-1:0]   SRC;
    logic [ADDR_BITS-1:0]   DST;
    logic [ADDR_BITS:0]     LEN;
    logic [DATA_WIDTH-1:0]  FILL_DATA;
    logic                   BUSY;
    logic                   DONE;
    logic                   ABORTED;
    logic [ADDR_BITS:0]     WORDS_DONE;
    logic                   MEM_WRITE;
    logic [ADDRESS_WIDTH-1:0] ADDRESS;
    logic [DATA_WIDTH-1:0]  WRITE_DATA;
    logic [DATA_WIDTH-1:0]  READ_DATA;

    modport master (
        input  START, MODE, ABORT, SRC, DST, LEN, FILL_DATA, READ_DATA,
        output BUSY, DONE, ABORTED, WORDS_DONE, MEM_WRITE, ADDRESS, WRITE_DATA
    );

    modport slave (
        output START, MODE, ABORT, SRC, DST, LEN, FILL_DATA, READ_DATA,
        input  BUSY, DONE, ABORTED, WORDS_DONE, MEM_WRITE, ADDRESS, WRITE_DATA
    );
endinterface

// File: rtl/dmem_dma_engine.sv
// ----------------------------------------------------------------------------
// dmem_dma_engine
// Block copy / block fill initiator for the 256 x 10-bit data memory.
// Software latches SRC/DST/LEN/MODE/FILL_DATA with a START pulse and waits
// for the one-cycle DONE pulse. COPY alternates a read cycle (RD) and a write
// cycle (WR); FILL writes one word per cycle (FILLW). ABORT ends an active
// transfer after the current access.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous, active-high
//   bus    dmem_dma_if.master (control, status and memory signals)
// ----------------------------------------------------------------------------
module dmem_dma_engine #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_WIDTH    = 10,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    dmem_dma_if.master bus
);

    localparam int PAD = ADDRESS_WIDTH - ADDR_BITS;
    localparam logic [ADDR_BITS:0] LAST_WORD = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILLW,
        S_FIN
    } state_t;

    state_t                  state;
    logic [ADDR_BITS-1:0]    src_ptr;
    logic [ADDR_BITS-1:0]    dst_ptr;
    logic [ADDR_BITS:0]      remaining;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    aborted_q;
    logic [ADDR_BITS:0]      words_q;
    logic                    mw_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;

    function automatic logic [ADDRESS_WIDTH-1:0] to_addr(input logic [ADDR_BITS-1:0] idx);
        return {{PAD{1'b0}}, idx};
    endfunction

    // Each branch programs the memory request for the cycle being entered,
    // so MEM_WRITE/ADDRESS come straight from flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            words_q   <= '0;
            mw_q      <= 1'b0;
            addr_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        src_ptr   <= bus.SRC;
                        dst_ptr   <= bus.DST;
                        remaining <= bus.LEN;
                        words_q   <= '0;
                        aborted_q <= 1'b0;
                        if (bus.LEN == '0) begin
                            state  <= S_FIN;
                            done_q <= 1'b1;
                        end else if (!bus.MODE) begin
                            state   <= S_RD;
                            busy_q  <= 1'b1;
                            mw_q    <= 1'b0;
                            addr_q  <= to_addr(bus.SRC);
                            wdata_q <= '0;
                        end else begin
                            state   <= S_FILLW;
                            busy_q  <= 1'b1;
                            mw_q    <= 1'b1;
                            addr_q  <= to_addr(bus.DST);
                            wdata_q <= bus.FILL_DATA;
                        end
                    end
                end

                S_RD: begin
                    if (bus.ABORT) begin
                        state     <= S_FIN;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        mw_q      <= 1'b0;
                        addr_q    <= '0;
                    end else begin
                        state  <= S_WR;
                        mw_q   <= 1'b1;
                        addr_q <= to_addr(dst_ptr);
                    end
                end

                S_WR: begin
                    src_ptr   <= src_ptr + 1'b1;
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    words_q   <= words_q + 1'b1;
                    if (bus.ABORT || remaining == LAST_WORD) begin
                        state     <= S_FIN;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        aborted_q <= bus.ABORT;
                        mw_q      <= 1'b0;
                        addr_q    <= '0;
                    end else begin
                        state  <= S_RD;
                        mw_q   <= 1'b0;
                        addr_q <= to_addr(src_ptr + 1'b1);
                    end
                end

                S_FILLW: begin
                    dst_ptr   <= dst_ptr + 1'b1;
                    remaining <= remaining - 1'b1;
                    words_q   <= words_q + 1'b1;
                    if (bus.ABORT || remaining == LAST_WORD) begin
                        state     <= S_FIN;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        aborted_q <= bus.ABORT;
                        mw_q      <= 1'b0;
                        addr_q    <= '0;
                        wdata_q   <= '0;
                    end else begin
                        addr_q <= to_addr(dst_ptr + 1'b1);
                    end
                end

                S_FIN: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    mw_q   <= 1'b0;
                    addr_q <= '0;
                end
            endcase
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.ABORTED    = aborted_q;
    assign bus.WORDS_DONE = words_q;
    assign bus.MEM_WRITE  = mw_q;
    assign bus.ADDRESS    = addr_q;
    // Copy writes forward the word fetched in the preceding RD cycle without
    // an extra register stage; wdata_q is zero outside FILL.
    assign bus.WRITE_DATA = (state == S_WR) ? bus.READ_DATA : wdata_q;

endmodule
